// File: rtl/apb_burst_master.sv
// APB4 burst master: splits valid/ready burst requests into single APB transfers
// with per-beat window decode, a PREADY timeout and one response per beat.
module apb_burst_master #(
  parameter int unsigned              ADDR_WIDTH     = 32,
  parameter int unsigned              DATA_WIDTH     = 32,
  parameter int unsigned              NUM_SLAVES     = 2,
  parameter int unsigned              LEN_WIDTH      = 4,
  parameter logic [ADDR_WIDTH-1:0]    BASE_ADDR      = 32'h0001_F000,
  parameter logic [ADDR_WIDTH-1:0]    STRIDE         = 32'h0001_0000,
  parameter logic [ADDR_WIDTH-1:0]    REGION_SIZE    = 32'h0000_1000,
  parameter int unsigned              TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [ADDR_WIDTH-1:0]     req_addr,
  input  logic [LEN_WIDTH-1:0]      req_len,
  input  logic [2:0]                req_prot,
  input  logic                      wdata_valid,
  output logic                      wdata_ready,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [DATA_WIDTH/8-1:0]   wstrb,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_WIDTH-1:0]     rsp_data,
  output logic                      rsp_err,
  output logic                      rsp_last,
  output logic [ADDR_WIDTH-1:0]     paddr,
  output logic [DATA_WIDTH-1:0]     pwdata,
  output logic [DATA_WIDTH/8-1:0]   pstrb,
  output logic [2:0]                pprot,
  output logic                      pwrite,
  output logic                      penable,
  output logic [NUM_SLAVES-1:0]     psel,
  input  logic [DATA_WIDTH-1:0]     prdata,
  input  logic                      pready,
  input  logic                      pslverr
);

  localparam int unsigned             STRB_W   = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0]   BEAT_INC = ADDR_WIDTH'(DATA_WIDTH / 8);
  localparam int unsigned             TMO_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TMO_W-1:0]        TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT_W = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  // Windows are compared in 64 bits so BASE + i*STRIDE + SIZE cannot wrap.
  function automatic logic [NUM_SLAVES-1:0] decode(input logic [ADDR_WIDTH-1:0] addr);
    logic [NUM_SLAVES-1:0] sel;
    logic [63:0]           lo;
    sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      lo     = 64'(BASE_ADDR) + 64'(i) * 64'(STRIDE);
      sel[i] = (64'(addr) >= lo) && (64'(addr) < lo + 64'(REGION_SIZE));
    end
    return sel;
  endfunction

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [LEN_WIDTH-1:0]    r_len;
  logic [LEN_WIDTH-1:0]    r_cnt;
  logic                    r_write;
  logic [2:0]              r_prot;
  logic                    r_miss;
  logic [TMO_W-1:0]        r_tmo;
  logic                    r_req_ready;
  logic                    r_wdata_ready;
  logic                    r_rsp_valid;
  logic [DATA_WIDTH-1:0]   r_rsp_data;
  logic                    r_rsp_err;
  logic                    r_rsp_last;
  logic [ADDR_WIDTH-1:0]   r_paddr;
  logic [DATA_WIDTH-1:0]   r_pwdata;
  logic [STRB_W-1:0]       r_pstrb;
  logic [2:0]              r_pprot;
  logic                    r_pwrite;
  logic                    r_penable;
  logic [NUM_SLAVES-1:0]   r_psel;

  logic                    w_enter_setup;
  logic [ADDR_WIDTH-1:0]   w_next_addr;
  logic                    w_next_write;
  logic [2:0]              w_next_prot;
  logic [NUM_SLAVES-1:0]   w_next_sel;
  logic                    w_tmo_hit;

  // Beat about to enter SETUP comes straight from the request, the next increment, or the held address.
  assign w_next_addr  = (r_state == ST_IDLE) ? req_addr :
                        (r_state == ST_RESP) ? r_addr + BEAT_INC : r_addr;
  assign w_next_write = (r_state == ST_IDLE) ? req_write : r_write;
  assign w_next_prot  = (r_state == ST_IDLE) ? req_prot  : r_prot;
  assign w_next_sel   = decode(w_next_addr);
  assign w_tmo_hit    = (TIMEOUT_CYCLES != 0) && (r_tmo == TMO_MAX);

  // Flags the clock edge on which the FSM moves into SETUP.
  always_comb begin
    w_enter_setup = 1'b0;
    case (r_state)
      ST_IDLE:   w_enter_setup = req_valid && r_req_ready && !req_write;
      ST_WAIT_W: w_enter_setup = wdata_valid && r_wdata_ready;
      ST_RESP:   w_enter_setup = rsp_ready && !r_rsp_last && !r_write;
      default:   w_enter_setup = 1'b0;
    endcase
  end

  // Burst FSM with every interface output registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_addr        <= '0;
      r_len         <= '0;
      r_cnt         <= '0;
      r_write       <= 1'b0;
      r_prot        <= 3'd0;
      r_miss        <= 1'b0;
      r_tmo         <= '0;
      r_req_ready   <= 1'b0;
      r_wdata_ready <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_data    <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_last    <= 1'b0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_pstrb       <= '0;
      r_pprot       <= 3'd0;
      r_pwrite      <= 1'b0;
      r_penable     <= 1'b0;
      r_psel        <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid && r_req_ready) begin
            r_req_ready <= 1'b0;
            r_addr      <= req_addr;
            r_len       <= req_len;
            r_write     <= req_write;
            r_prot      <= req_prot;
            r_cnt       <= '0;
            if (req_write) begin
              r_state       <= ST_WAIT_W;
              r_wdata_ready <= 1'b1;
            end else begin
              r_state <= ST_SETUP;
            end
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        ST_WAIT_W: begin
          if (wdata_valid && r_wdata_ready) begin
            r_wdata_ready <= 1'b0;
            r_state       <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (r_miss) begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_data  <= '0;
            r_rsp_last  <= (r_cnt == r_len);
          end else begin
            r_state   <= ST_ACCESS;
            r_penable <= 1'b1;
            r_tmo     <= '0;
          end
        end
        ST_ACCESS: begin
          if (pready || w_tmo_hit) begin
            r_state     <= ST_RESP;
            r_psel      <= '0;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_last  <= (r_cnt == r_len);
            r_rsp_err   <= pready ? pslverr : 1'b1;
            r_rsp_data  <= (pready && !pslverr && !r_write) ? prdata : '0;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            if (r_rsp_last) begin
              r_state     <= ST_IDLE;
              r_req_ready <= 1'b1;
            end else begin
              r_addr <= r_addr + BEAT_INC;
              r_cnt  <= r_cnt + 1'b1;
              if (r_write) begin
                r_state       <= ST_WAIT_W;
                r_wdata_ready <= 1'b1;
              end else begin
                r_state <= ST_SETUP;
              end
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // A decode miss leaves the APB bus idle and the last address/direction held.
      if (w_enter_setup) begin
        r_psel <= w_next_sel;
        r_miss <= ~|w_next_sel;
        if (|w_next_sel) begin
          r_paddr  <= w_next_addr;
          r_pwrite <= w_next_write;
          r_pprot  <= w_next_prot;
          r_pstrb  <= w_next_write ? wstrb : '0;
          r_pwdata <= w_next_write ? wdata : r_pwdata;
        end
      end
    end
  end

  assign req_ready   = r_req_ready;
  assign wdata_ready = r_wdata_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;
  assign rsp_err     = r_rsp_err;
  assign rsp_last    = r_rsp_last;
  assign paddr       = r_paddr;
  assign pwdata      = r_pwdata;
  assign pstrb       = r_pstrb;
  assign pprot       = r_pprot;
  assign pwrite      = r_pwrite;
  assign penable     = r_penable;
  assign psel        = r_psel;

endmodule

// File: tb/tb_apb_burst_master.sv
// Scoreboard bench for apb_burst_master: bursts are expanded into per-beat
// expectations by a window/arithmetic reference model; monitors pop and compare.
module tb_apb_burst_master;

  localparam int          NS     = 2;
  localparam int          TMO    = 16;
  localparam logic [31:0] BASE   = 32'h0001_F000;
  localparam logic [31:0] STRIDE = 32'h0001_0000;
  localparam logic [31:0] REGION = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr;
  logic [3:0]  req_len;
  logic [2:0]  req_prot;
  logic        wdata_valid, wdata_ready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_last;
  logic [31:0] rsp_data;
  logic [31:0] paddr, pwdata, prdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic        pwrite, penable, pready, pslverr;
  logic [1:0]  psel;

  apb_burst_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len), .req_prot(req_prot),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata), .wstrb(wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .rsp_last(rsp_last),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot), .pwrite(pwrite),
    .penable(penable), .psel(psel), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] data; bit err; bit last; } rsp_t;
  typedef struct { logic [31:0] addr; logic [1:0] sel; bit wr; logic [3:0] strb;
                   logic [2:0] prot; logic [31:0] wd; } apb_t;
  typedef struct { logic [31:0] d; logic [3:0] s; } wbeat_t;

  rsp_t   exp_rsp[$];
  apb_t   exp_apb[$];
  wbeat_t wq[$];

  int n_cmp = 0;
  int n_bad = 0;
  int psel_cyc = 0;
  int pen_cyc = 0;
  int wait_states = 0;
  bit stall = 1'b0;
  int bp_mode = 0;
  int wcnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16] + 16'h1234};
  endfunction

  function automatic bit slv_err(input logic [31:0] a);
    return a[6:2] == 5'd9;
  endfunction

  // Window index for an address, or -1 when it falls in no slave window.
  function automatic int slave_of(input logic [31:0] a);
    logic [31:0] off;
    if (a < BASE) return -1;
    off = a - BASE;
    if (off / STRIDE >= NS) return -1;
    if (off % STRIDE >= REGION) return -1;
    return int'(off / STRIDE);
  endfunction

  // APB slave: fixed wait states, or never ready when stalled.
  always @(posedge clk) begin
    if (psel != 2'b00 && penable && !pready) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end
  assign pready  = !stall && (wait_states == 0 || (penable && wcnt >= wait_states));
  assign prdata  = mem_word(paddr);
  assign pslverr = slv_err(paddr);

  // Write-data source fed from the per-beat queue filled at issue time.
  initial begin
    bit fire;
    wdata_valid = 1'b0; wdata = 32'h0; wstrb = 4'h0;
    forever begin
      @(negedge clk);
      fire = wdata_valid && wdata_ready;
      @(posedge clk); #1;
      if (fire && wq.size() > 0) void'(wq.pop_front());
      wdata_valid = (wq.size() > 0);
      if (wq.size() > 0) begin
        wdata = wq[0].d;
        wstrb = wq[0].s;
      end
    end
  end

  // Response backpressure: 0 always ready, 1 random, 2 held low.
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (bp_mode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = ($urandom_range(0, 2) != 0);
        default: rsp_ready = 1'b0;
      endcase
    end
  end

  // Response monitor.
  initial begin
    rsp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && rsp_valid && rsp_ready) begin
        if (exp_rsp.size() == 0) chk("rsp_unexpected", rsp_valid, 1'b0);
        else begin
          e = exp_rsp.pop_front();
          chk("rsp_data", rsp_data, e.data);
          chk("rsp_err", rsp_err, e.err);
          chk("rsp_last", rsp_last, e.last);
        end
      end
    end
  end

  // APB monitor: checks each completed transfer and counts select/enable cycles.
  initial begin
    apb_t p;
    forever begin
      @(negedge clk);
      if (psel != 2'b00) begin
        psel_cyc++;
        chk("psel_onehot", $countones(psel), 1);
      end
      if (penable) pen_cyc++;
      if (rst_n && psel != 2'b00 && penable && pready) begin
        if (exp_apb.size() == 0) chk("apb_unexpected", psel, 2'b00);
        else begin
          p = exp_apb.pop_front();
          chk("paddr", paddr, p.addr);
          chk("psel", psel, p.sel);
          chk("pwrite", pwrite, p.wr);
          chk("pstrb", pstrb, p.strb);
          chk("pprot", pprot, p.prot);
          if (p.wr) chk("pwdata", pwdata, p.wd);
        end
      end
    end
  end

  // Expands a burst into expected beats, then performs the request handshake.
  task automatic issue(input bit wr, input logic [31:0] a, input logic [3:0] len,
                       input logic [2:0] prot);
    int n;
    for (int i = 0; i <= int'(len); i++) begin
      logic [31:0] ba;
      int s;
      rsp_t r;
      apb_t p;
      wbeat_t w;
      ba  = a + 32'(i * 4);
      s   = slave_of(ba);
      w.d = $urandom;
      w.s = 4'($urandom_range(0, 15));
      if (wr) wq.push_back(w);
      r.last = (i == int'(len));
      if (s < 0 || stall) begin
        r.data = 32'h0; r.err = 1'b1;
      end else begin
        r.err  = slv_err(ba);
        r.data = (wr || r.err) ? 32'h0 : mem_word(ba);
      end
      exp_rsp.push_back(r);
      if (s >= 0 && !stall) begin
        p.addr = ba; p.sel = 2'(1 << s); p.wr = wr;
        p.strb = wr ? w.s : 4'h0; p.prot = prot; p.wd = w.d;
        exp_apb.push_back(p);
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_len = len; req_prot = prot;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready && n < 500);
    chk("req_accept", req_ready, 1'b1);
    if (req_ready) @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_rsp.size() != 0 || !req_ready) && n < 3000) begin
      @(negedge clk); n++;
    end
    chk("drain", exp_rsp.size(), 0);
  endtask

  // Single-beat read; latency counted in negedges after the request handshake.
  task automatic timed_read(input logic [31:0] a, input int exp_lat, input string nm);
    int lat = 0;
    issue(1'b0, a, 4'd0, 3'd2);
    do begin @(negedge clk); lat++; end while (!rsp_valid && lat < 100);
    chk(nm, lat, exp_lat);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ctrl"}, {req_ready, wdata_ready, rsp_valid, rsp_err, rsp_last, penable, pwrite, psel}, 0);
    chk({nm, "_paddr"}, paddr, 0);
    chk({nm, "_pwdata"}, pwdata, 0);
    chk({nm, "_misc"}, {pstrb, pprot, rsp_data}, 0);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] a;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_len = 4'h0; req_prot = 3'h0;
    repeat (3) @(posedge clk);
    #1 chk_all_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("req_ready_after_reset", req_ready, 1'b1);

    psel_cyc = 0; pen_cyc = 0;
    timed_read(32'h0001_F004, 3, "read_latency");
    wait_idle();
    chk("read_psel_cycles", psel_cyc, 2);
    chk("read_penable_cycles", pen_cyc, 1);

    wait_states = 2;
    issue(1'b1, 32'h0002_F000, 4'd3, 3'd5);
    wait_idle();
    wait_states = 0;

    bp_mode = 2;
    issue(1'b0, 32'h0001_F010, 4'd1, 3'd0);
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 100);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", rsp_valid, 1'b1);
      chk("bp_hold_data", rsp_data, mem_word(32'h0001_F010));
      chk("bp_no_setup", psel, 2'b00);
    end
    bp_mode = 0;
    wait_idle();

    psel_cyc = 0;
    timed_read(32'h0003_0000, 2, "decerr_latency");
    wait_idle();
    chk("decerr_psel_cycles", psel_cyc, 0);

    stall = 1'b1;
    timed_read(32'h0001_F020, TMO + 3, "timeout_latency");
    chk("timeout_psel_low", psel, 2'b00);
    wait_idle();
    stall = 1'b0;
    timed_read(32'h0001_F024, 3, "post_timeout_latency");
    wait_idle();

    issue(1'b0, 32'h0001_FFFC, 4'd1, 3'd1);
    wait_idle();
    issue(1'b1, 32'h0002_FFF8, 4'd2, 3'd3);
    wait_idle();

    stall = 1'b1;
    issue(1'b0, 32'h0001_F000, 4'd0, 3'd0);
    n = 0;
    do begin @(negedge clk); n++; end while (!penable && n < 50);
    chk("reach_access", penable, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_reset");
    exp_rsp.delete(); exp_apb.delete(); wq.delete();
    stall = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("req_ready_after_midburst_reset", req_ready, 1'b1);

    bp_mode = 1;
    for (int t = 0; t < 40; t++) begin
      wait_states = $urandom_range(0, 2);
      case ($urandom_range(0, 4))
        0:       a = BASE + 32'($urandom_range(0, 1023)) * 32'd4;
        1:       a = BASE + STRIDE + 32'($urandom_range(0, 1023)) * 32'd4;
        2:       a = BASE + REGION - 32'($urandom_range(1, 4)) * 32'd4;
        3:       a = BASE + STRIDE + REGION - 32'($urandom_range(1, 4)) * 32'd4;
        default: a = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      endcase
      issue(1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
      wait_idle();
    end
    bp_mode = 0;
    wait_states = 0;
    repeat (4) @(negedge clk);
    chk("exp_rsp_empty", exp_rsp.size(), 0);
    chk("exp_apb_empty", exp_apb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/apb_burst_master.md
# apb_burst_master

Parametrised APB4 master engine for the AXI2APB bridge. It accepts burst read/write requests from the AXI front end on a valid/ready interface and splits them into single APB transfers with incrementing addresses. It decodes each beat to one of NUM_SLAVES address windows and returns one response per beat. Undecodable addresses and stalled slaves are reported as per-beat errors; it never defaults to a slave.

## Interface
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width (32 or 64); byte increment per beat = DATA_WIDTH/8
- NUM_SLAVES, 2, number of APB slaves / PSEL bits
- LEN_WIDTH, 4, burst length field width; beats = req_len+1
- BASE_ADDR, 32'h0001_F000, start of slave 0 window
- STRIDE, 32'h0001_0000, distance between consecutive slave windows
- REGION_SIZE, 32'h0000_1000, window size per slave
- TIMEOUT_CYCLES, 16, max ACCESS cycles without PREADY; 0 disables the timeout
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid / req_ready  in/out  1  request handshake
- req_write  in  1  1 = write burst
- req_addr  in  ADDR_WIDTH  first-beat address
- req_len  in  LEN_WIDTH  beats minus one
- req_prot  in  3  PPROT value held for the whole burst
- wdata_valid / wdata_ready  in/out  1  per-beat write data handshake
- wdata  in  DATA_WIDTH  write data
- wstrb  in  DATA_WIDTH/8  byte strobes
- rsp_valid / rsp_ready  out/in  1  per-beat response handshake
- rsp_data  out  DATA_WIDTH  read data; 0 for writes and errors
- rsp_err  out  1  PSLVERR, decode error or timeout
- rsp_last  out  1  final beat of burst
- paddr, pwdata, pstrb, pprot, pwrite, penable  out  APB4 master signals
- psel  out  NUM_SLAVES  one-hot slave select
- prdata, pready, pslverr  in  muxed slave return signals

## Operation
- States: IDLE, WAIT_W, SETUP, ACCESS, RESP. All outputs are driven from flops.
- **IDLE:** req_ready=1. On handshake, latch addr/len/write/prot and clear the beat counter. Next state is WAIT_W for writes, SETUP for reads.
- **WAIT_W:** wdata_ready=1. On handshake, latch wdata/wstrb and go to SETUP.
- **Decode:** slave i is hit when addr ∈ [BASE_ADDR+i·STRIDE, BASE_ADDR+i·STRIDE+REGION_SIZE).
  - Hit: SETUP drives psel one-hot, penable=0, and paddr/pwrite/pprot/pwdata/pstrb.
  - No hit: no APB cycle. Go straight to RESP with rsp_err=1, rsp_data=0.
- **Strobes:** pstrb = latched wstrb on writes and 0 on reads. pwdata is don't-care on reads.
- **ACCESS:** penable=1 with psel held.
  - On pready=1, capture prdata (reads only) and pslverr, then go to RESP.
  - The timeout counter increments each ACCESS cycle without pready. When it reaches TIMEOUT_CYCLES, drop psel/penable and go to RESP with rsp_err=1.
- **RESP:** rsp_valid=1, with rsp_last=1 when beat counter == req_len. On handshake:
  - If last, go to IDLE.
  - Otherwise addr += DATA_WIDTH/8 (mod 2^ADDR_WIDTH), increment the counter, and go to WAIT_W or SETUP.
- **Errors:** an error does not abort the burst. Every beat is issued and answered, and each beat is decoded independently, so crossing a window is handled per beat.
- **APB outputs outside SETUP/ACCESS:** psel=0, penable=0; paddr/pwrite hold their last values.

## Timing
- **Reset values:** every output 0, including req_ready, wdata_ready, rsp_valid, psel and penable. Asynchronous assertion returns the block to IDLE immediately; an in-flight burst is dropped with no response. The first cycle after release has req_ready=1.
- **Read:** handshake at T, SETUP T+1, ACCESS T+2 (pready=1), rsp_valid T+3.
- **Write:** add one cycle for WAIT_W when wdata_valid is already high.
- **Throughput:** 3 cycles/beat for reads and 4 for writes, with zero-wait slaves and rsp_ready=1.
- **Decode error:** rsp_valid appears 1 cycle after SETUP would have started (T+2 for a read).
- **Timeout:** with TIMEOUT_CYCLES=N, rsp_valid appears N+1 cycles after ACCESS entry; psel is low on the same cycle.
- **Backpressure:**
  - rsp_valid and rsp fields are held stable until rsp_ready.
  - pready is ignored outside ACCESS.
  - req_valid is ignored outside IDLE.

## Test plan
- **Single read:** read 0x0001_F004 len 0, pready=1, prdata=0xCAFE_0001 → psel=2'b01 for 2 cycles, penable high 1 cycle; rsp_data=0xCAFE_0001, rsp_err=0, rsp_last=1 at T+3.
- **Write burst with waits:** write 0x0002_F000 len 3, wstrb=4'b0011, 2 wait states per beat → paddr 0x..F000/F004/F008/F00C, psel=2'b10, pstrb=0011, pprot=req_prot; 4 responses, rsp_last only on the 4th.
- **Backpressure:** read len 1 with rsp_ready held low 5 cycles → response stable; no second SETUP until the handshake.
- **Decode error:** read 0x0003_0000 → psel never asserted; rsp_err=1, rsp_data=0 at T+2.
- **Timeout:** TIMEOUT_CYCLES=16, pready stuck low → psel drops after 16 ACCESS cycles; rsp_err=1; next request accepted normally.
- **Boundary and reset:** burst len 1 from 0x0001_FFFC → beat 0 hits slave 0, beat 1 (0x0002_0000) is a decode error. Assert rst_n mid-ACCESS → all outputs 0 asynchronously; req_ready=1 after release.
